// File: rtl/exec_ctrl_unit_pkg.sv
// Shared definitions for the execute/control slice of the 16-bit CPU.
// Holds the opcode and branch-condition encodings, the bit positions of the
// control vector, the link register index, and a small decode helper.
package exec_ctrl_unit_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_PADDSB = 4'h1,
    OP_SUB    = 4'h2,
    OP_AND    = 4'h3,
    OP_NOR    = 4'h4,
    OP_SLL    = 4'h5,
    OP_SRL    = 4'h6,
    OP_SRA    = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LHB    = 4'hA,
    OP_LLB    = 4'hB,
    OP_B      = 4'hC,
    OP_CALL   = 4'hD,
    OP_JR     = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    CC_NE = 3'b000,
    CC_EQ = 3'b001,
    CC_GT = 3'b010,
    CC_LT = 3'b011,
    CC_GE = 3'b100,
    CC_LE = 3'b101,
    CC_OV = 3'b110,
    CC_UN = 3'b111
  } cond_e;

  localparam int CTRL_REG_WR  = 0;
  localparam int CTRL_MEM2REG = 1;
  localparam int CTRL_MEM_WR  = 2;
  localparam int CTRL_HALT    = 3;
  localparam int CTRL_CALL    = 4;
  localparam int CTRL_JR      = 5;
  localparam int CTRL_BRANCH  = 6;
  localparam int CTRL_RSVD    = 7;

  localparam logic [3:0] LINK_REG = 4'd15;

  // Opcodes that write a result back into the register file.
  function automatic logic op_writes_reg(input opcode_e op);
    logic wr;
    case (op)
      OP_ADD, OP_PADDSB, OP_SUB, OP_AND, OP_NOR,
      OP_SLL, OP_SRL, OP_SRA, OP_LW,
      OP_LHB, OP_LLB, OP_CALL: wr = 1'b1;
      default:                 wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/exec_ctrl_unit_branch_cond.sv
// Branch condition evaluator.
// Ports:
//   cond   - 3-bit condition code from the instruction
//   z_flag - registered zero flag
//   n_flag - registered negative flag
//   v_flag - registered overflow flag
//   br     - condition satisfied
module exec_ctrl_unit_branch_cond
  import exec_ctrl_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z_flag,
  input  logic       n_flag,
  input  logic       v_flag,
  output logic       br
);

  cond_e cc;

  always_comb begin
    cc = cond_e'(cond);
    br = 1'b0;
    case (cc)
      CC_NE: br = ~z_flag;
      CC_EQ: br = z_flag;
      CC_GT: br = ~z_flag & ~n_flag;
      CC_LT: br = n_flag;
      CC_GE: br = z_flag | ~n_flag;
      CC_LE: br = n_flag | z_flag;
      CC_OV: br = v_flag;
      CC_UN: br = 1'b1;
      default: br = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_ctrl_unit.sv
// Decode / execute / branch-resolve block of the single-cycle 16-bit CPU.
// Everything except the Z/N/V flag register is combinational from the inputs.
// Ports:
//   clk, rst_n        - clock; asynchronous active-low reset of the flags
//   operation         - current instruction
//   pc                - current program counter (CALL link value source)
//   input1, input2    - register-file values of rs and rt
//   rd, rs, rt        - decoded register indices
//   cond, imm, call   - raw branch condition / branch offset / call offset
//   ctrl_signals      - control vector (bit positions in the package)
//   result            - ALU result, memory address, jump target or link value
//   Z, N, V           - registered flags
//   br                - branch condition evaluated on the registered flags
module exec_ctrl_unit
  import exec_ctrl_unit_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] operation,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] input1,
  input  logic [DW-1:0] input2,
  output logic [3:0]    rd,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [2:0]    cond,
  output logic [8:0]    imm,
  output logic [11:0]   call,
  output logic [7:0]    ctrl_signals,
  output logic [DW-1:0] result,
  output logic          Z,
  output logic          N,
  output logic          V,
  output logic          br
);

  // Saturating signed add; returns {saturated, value}. Overflow shows as the
  // two top bits of the one-bit-wider sum disagreeing, and the sign of the
  // true sum picks the clamp direction.
  function automatic logic [DW:0] sat_add(input logic signed [DW-1:0] a,
                                          input logic signed [DW-1:0] b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) return {1'b1, s[DW], {(DW-1){~s[DW]}}};
    return {1'b0, s[DW-1:0]};
  endfunction

  function automatic logic [DW:0] sat_sub(input logic signed [DW-1:0] a,
                                          input logic signed [DW-1:0] b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} - {b[DW-1], b};
    if (s[DW] != s[DW-1]) return {1'b1, s[DW], {(DW-1){~s[DW]}}};
    return {1'b0, s[DW-1:0]};
  endfunction

  function automatic logic [8:0] sat_byte(input logic signed [7:0] a,
                                          input logic signed [7:0] b);
    logic signed [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) return {1'b1, s[8], {7{~s[8]}}};
    return {1'b0, s[7:0]};
  endfunction

  opcode_e              op;
  logic [3:0]           shamt;
  logic signed [DW-1:0] in1_s;
  logic [DW:0]          add_w;
  logic [DW:0]          sub_w;
  logic [8:0]           hi_w;
  logic [8:0]           lo_w;
  logic                 upd_znv;
  logic                 upd_z;
  logic                 ovf;

  logic z_d, n_d, v_d;
  logic z_q, n_q, v_q;

  assign op    = opcode_e'(operation[15:12]);
  assign shamt = operation[3:0];
  assign in1_s = input1;

  assign cond = operation[11:9];
  assign imm  = operation[8:0];
  assign call = operation[11:0];

  // Field and control decode.
  always_comb begin
    rd           = operation[11:8];
    rs           = operation[7:4];
    rt           = operation[3:0];
    ctrl_signals = '0;
    case (op)
      OP_LW:   ctrl_signals[CTRL_MEM2REG] = 1'b1;
      OP_SW: begin
        rt                          = operation[11:8];
        ctrl_signals[CTRL_MEM_WR]   = 1'b1;
      end
      OP_LHB:  rs = operation[11:8];
      OP_B:    ctrl_signals[CTRL_BRANCH] = 1'b1;
      OP_CALL: begin
        rd                          = LINK_REG;
        ctrl_signals[CTRL_CALL]     = 1'b1;
      end
      OP_JR:   ctrl_signals[CTRL_JR]   = 1'b1;
      OP_HLT:  ctrl_signals[CTRL_HALT] = 1'b1;
      default: ;
    endcase
    ctrl_signals[CTRL_REG_WR] = op_writes_reg(op);
    ctrl_signals[CTRL_RSVD]   = 1'b0;
  end

  // Execute: result and the flag values to capture at the next edge.
  always_comb begin
    add_w   = sat_add(input1, input2);
    sub_w   = sat_sub(input1, input2);
    hi_w    = sat_byte(input1[15:8], input2[15:8]);
    lo_w    = sat_byte(input1[7:0], input2[7:0]);
    result  = '0;
    upd_znv = 1'b0;
    upd_z   = 1'b0;
    ovf     = 1'b0;
    case (op)
      OP_ADD: begin
        result  = add_w[DW-1:0];
        ovf     = add_w[DW];
        upd_znv = 1'b1;
      end
      OP_PADDSB: begin
        result  = {hi_w[7:0], lo_w[7:0]};
        ovf     = hi_w[8] | lo_w[8];
        upd_znv = 1'b1;
      end
      OP_SUB: begin
        result  = sub_w[DW-1:0];
        ovf     = sub_w[DW];
        upd_znv = 1'b1;
      end
      OP_AND: begin
        result = input1 & input2;
        upd_z  = 1'b1;
      end
      OP_NOR: begin
        result = ~(input1 | input2);
        upd_z  = 1'b1;
      end
      OP_SLL: begin
        result = input1 << shamt;
        upd_z  = 1'b1;
      end
      OP_SRL: begin
        result = input1 >> shamt;
        upd_z  = 1'b1;
      end
      OP_SRA: begin
        result = in1_s >>> shamt;
        upd_z  = 1'b1;
      end
      OP_LW, OP_SW: result = input1 + {{(DW-4){operation[3]}}, operation[3:0]};
      OP_LHB:  result = {operation[7:0], input1[7:0]};
      OP_LLB:  result = {{(DW-8){operation[7]}}, operation[7:0]};
      OP_CALL: result = pc + {{(DW-1){1'b0}}, 1'b1};
      OP_JR:   result = input1;
      default: result = '0;
    endcase

    z_d = z_q;
    n_d = n_q;
    v_d = v_q;
    if (upd_znv || upd_z) z_d = (result == '0);
    if (upd_znv) begin
      n_d = result[DW-1];
      v_d = ovf;
    end
  end

  // Flag register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
      v_q <= v_d;
    end
  end

  assign Z = z_q;
  assign N = n_q;
  assign V = v_q;

  exec_ctrl_unit_branch_cond u_branch_cond (
    .cond   (cond),
    .z_flag (z_q),
    .n_flag (n_q),
    .v_flag (v_q),
    .br     (br)
  );

endmodule

// File: tb/tb_exec_ctrl_unit.sv
module tb_exec_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] operation = '0;
  logic [15:0] pc = '0;
  logic [15:0] input1 = '0;
  logic [15:0] input2 = '0;
  logic [3:0]  rd, rs, rt;
  logic [2:0]  cond;
  logic [8:0]  imm;
  logic [11:0] call;
  logic [7:0]  ctrl_signals;
  logic [15:0] result;
  logic        Z, N, V, br;

  always #5 clk = ~clk;

  exec_ctrl_unit #(.DW(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .operation    (operation),
    .pc           (pc),
    .input1       (input1),
    .input2       (input2),
    .rd           (rd),
    .rs           (rs),
    .rt           (rt),
    .cond         (cond),
    .imm          (imm),
    .call         (call),
    .ctrl_signals (ctrl_signals),
    .result       (result),
    .Z            (Z),
    .N            (N),
    .V            (V),
    .br           (br)
  );

  typedef struct {
    string       name;
    logic [15:0] res;
    bit          chk_res;
    logic [7:0]  ctrl;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [2:0]  cond;
    logic [8:0]  imm;
    logic [11:0] call;
    logic        z;
    logic        n;
    logic        v;
    logic        br;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference flag state: current (what the DUT shows now) and pending
  // (what the DUT will capture on the next rising edge).
  bit mz = 0, mn = 0, mv = 0;
  bit pz = 0, pn = 0, pv = 0;

  function automatic int sx16(input logic [15:0] x);
    return int'($signed(x));
  endfunction
  function automatic int sx8(input logic [7:0] x);
    return int'($signed(x));
  endfunction
  function automatic int sx4(input logic [3:0] x);
    return int'($signed(x));
  endfunction
  function automatic int clamp(input int s, input int lo, input int hi);
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  task automatic cmp(input string nm, input string fld,
                     input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are settled by the falling edge; check one record.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_vec++;
      if (e.chk_res) cmp(e.name, "result", result, e.res);
      cmp(e.name, "ctrl", 16'(ctrl_signals), 16'(e.ctrl));
      cmp(e.name, "rd",   16'(rd),   16'(e.rd));
      cmp(e.name, "rs",   16'(rs),   16'(e.rs));
      cmp(e.name, "rt",   16'(rt),   16'(e.rt));
      cmp(e.name, "cond", 16'(cond), 16'(e.cond));
      cmp(e.name, "imm",  16'(imm),  16'(e.imm));
      cmp(e.name, "call", 16'(call), 16'(e.call));
      cmp(e.name, "Z",    16'(Z),    16'(e.z));
      cmp(e.name, "N",    16'(N),    16'(e.n));
      cmp(e.name, "V",    16'(V),    16'(e.v));
      cmp(e.name, "br",   16'(br),   16'(e.br));
    end
  end

  // Driver + reference model: one instruction per cycle.
  task automatic apply(input string name, input logic [15:0] op,
                       input logic [15:0] p, input logic [15:0] a,
                       input logic [15:0] b, input bit rst_now = 0,
                       input bit release_rst = 0);
    exp_t        e;
    int          ia, ib, s, h, l;
    logic [15:0] r;
    bit          ovf, upd3, upd1;
    @(posedge clk);
    if (rst_n) begin
      mz = pz; mn = pn; mv = pv;
    end
    #1;
    operation = op; pc = p; input1 = a; input2 = b;
    if (rst_now) begin
      rst_n = 1'b0;
      mz = 0; mn = 0; mv = 0;
    end
    if (release_rst) rst_n = 1'b1;

    ia = sx16(a); ib = sx16(b);
    r = '0; ovf = 0; upd3 = 0; upd1 = 0;
    e.name = name; e.chk_res = 1; e.ctrl = 8'h00;
    e.rd = op[11:8]; e.rs = op[7:4]; e.rt = op[3:0];
    e.cond = op[11:9]; e.imm = op[8:0]; e.call = op[11:0];
    case (op[15:12])
      4'h0: begin s = ia + ib; ovf = (s != clamp(s, -32768, 32767));
                  r = 16'(clamp(s, -32768, 32767)); upd3 = 1; e.ctrl = 8'h01; end
      4'h1: begin
        h = sx8(a[15:8]) + sx8(b[15:8]);
        l = sx8(a[7:0]) + sx8(b[7:0]);
        ovf = (h != clamp(h, -128, 127)) || (l != clamp(l, -128, 127));
        r = {8'(clamp(h, -128, 127)), 8'(clamp(l, -128, 127))};
        upd3 = 1; e.ctrl = 8'h01;
      end
      4'h2: begin s = ia - ib; ovf = (s != clamp(s, -32768, 32767));
                  r = 16'(clamp(s, -32768, 32767)); upd3 = 1; e.ctrl = 8'h01; end
      4'h3: begin r = a & b;            upd1 = 1; e.ctrl = 8'h01; end
      4'h4: begin r = ~(a | b);         upd1 = 1; e.ctrl = 8'h01; end
      4'h5: begin r = a << op[3:0];     upd1 = 1; e.ctrl = 8'h01; end
      4'h6: begin r = a >> op[3:0];     upd1 = 1; e.ctrl = 8'h01; end
      4'h7: begin r = 16'(ia >>> op[3:0]); upd1 = 1; e.ctrl = 8'h01; end
      4'h8: begin r = 16'(ia + sx4(op[3:0])); e.ctrl = 8'h03; end
      4'h9: begin r = 16'(ia + sx4(op[3:0])); e.rt = op[11:8]; e.ctrl = 8'h04; end
      4'hA: begin r = {op[7:0], a[7:0]}; e.rs = op[11:8]; e.ctrl = 8'h01; end
      4'hB: begin r = 16'(sx8(op[7:0])); e.ctrl = 8'h01; end
      4'hC: begin e.chk_res = 0; e.ctrl = 8'h40; end
      4'hD: begin r = p + 16'd1; e.rd = 4'd15; e.ctrl = 8'h11; end
      4'hE: begin r = a; e.ctrl = 8'h20; end
      default: begin e.chk_res = 0; e.ctrl = 8'h08; end
    endcase
    e.res = r;
    e.z = mz; e.n = mn; e.v = mv;
    case (op[11:9])
      3'd0: e.br = !mz;
      3'd1: e.br = mz;
      3'd2: e.br = !mz && !mn;
      3'd3: e.br = mn;
      3'd4: e.br = mz || !mn;
      3'd5: e.br = mn || mz;
      3'd6: e.br = mv;
      default: e.br = 1'b1;
    endcase
    sbq.push_back(e);

    pz = mz; pn = mn; pv = mv;
    if (upd3 || upd1) pz = (r == 16'h0000);
    if (upd3) begin pn = r[15]; pv = ovf; end
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'($urandom_range(0, 3));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    apply("reset",    16'h0000, 16'h0000, 16'h1111, 16'h2222, 1'b1);
    apply("add_sat",  16'h0123, 16'h0000, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    apply("sub_zero", 16'h2012, 16'h0000, 16'h0005, 16'h0005);
    apply("b_eq",     16'hC205, 16'h0000, 16'h0000, 16'h0000);
    apply("b_ne",     16'hC005, 16'h0000, 16'h0000, 16'h0000);
    apply("paddsb",   16'h1012, 16'h0000, 16'h7F10, 16'h0120);
    apply("and_zero", 16'h3012, 16'h0000, 16'h00F0, 16'h0F00);
    apply("nor",      16'h4012, 16'h0000, 16'hFFFF, 16'h0000);
    apply("call",     16'hD010, 16'h0020, 16'h0000, 16'h0000);
    apply("jr",       16'hE010, 16'h0000, 16'h1234, 16'h0000);
    apply("lw",       16'h812F, 16'h0000, 16'h0010, 16'h0000);
    apply("sw",       16'h9341, 16'h0000, 16'h0020, 16'h0055);
    apply("sub_min",  16'h2012, 16'h0000, 16'h8000, 16'h0001);
    apply("sll0",     16'h5010, 16'h0000, 16'hA5A5, 16'h0000);
    apply("sra4",     16'h7014, 16'h0000, 16'h8000, 16'h0000);
    apply("srl4",     16'h6014, 16'h0000, 16'h8000, 16'h0000);
    apply("lhb",      16'hA3AB, 16'h0000, 16'h1234, 16'h0000);
    apply("llb",      16'hB380, 16'h0000, 16'h0000, 16'h0000);
    apply("neg",      16'h2012, 16'h0000, 16'h0000, 16'h0001);
    apply("hlt_n",    16'hF000, 16'h0000, 16'h0000, 16'h0000);
    apply("hlt_hold", 16'hF000, 16'h0000, 16'h0000, 16'h0000);
    apply("rst_mid",  16'hF000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    apply("post_rst", 16'hF000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      apply("rand", 16'($urandom), 16'($urandom), pick_val(), pick_val());
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending records expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
